// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared types and constants for the vending-machine
//                transaction sequencer: FSM state encoding, credit width,
//                coin value table and the coin-to-credit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    // Credit and prices are carried in 10-cent units.
    localparam int c_CREDIT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_RETURN   = 2'd3
    } vend_state_t;

    // Coin type codes as delivered by the coin acceptor.
    localparam logic [1:0] c_COIN_10C     = 2'd0;
    localparam logic [1:0] c_COIN_50C     = 2'd1;
    localparam logic [1:0] c_COIN_100C    = 2'd2;
    localparam logic [1:0] c_COIN_INVALID = 2'd3;

    // Coin values in credit units.
    localparam logic [c_CREDIT_W-1:0] c_VAL_10C  = 8'd1;
    localparam logic [c_CREDIT_W-1:0] c_VAL_50C  = 8'd5;
    localparam logic [c_CREDIT_W-1:0] c_VAL_100C = 8'd10;

    // Invalid coins map to zero; callers reject them separately.
    function automatic logic [c_CREDIT_W-1:0] coin_units(input logic [1:0] code);
        logic [c_CREDIT_W-1:0] v;
        v = '0;
        case (code)
            c_COIN_10C:  v = c_VAL_10C;
            c_COIN_50C:  v = c_VAL_50C;
            c_COIN_100C: v = c_VAL_100C;
            default:     v = '0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sec_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sec_tick_timer
//  Description : Counts external one-cycle tick pulses down from a loaded
//                value. done is a one-cycle pulse coincident with the tick
//                that exhausts the count, so the consumer can act on the
//                same clock edge that registers that tick.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                load/load_val - synchronous (re)load, wins over a tick
//                run           - ticks are only counted while high
//                tick          - one-cycle pulse to count
//                done          - final tick seen (combinational from regs)
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    input  logic             tick,
    output logic             done
);

    logic [WIDTH-1:0] r_remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (load) begin
            r_remaining <= load_val;
        end else if (run && tick && (r_remaining != '0)) begin
            r_remaining <= r_remaining - WIDTH'(1);
        end
    end

    // A reload in the same cycle means fresh activity, so it suppresses expiry.
    assign done = run && tick && !load && (r_remaining <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vend_controller
//  Description : Vending-machine transaction sequencer. Accumulates coin
//                credit, validates a product selection against its price,
//                times the dispense motor and issues the change strobe.
//                All timing comes from the external 1 Hz / 2 Hz trigger
//                pulses. Every output is registered.
//  Ports       : clk, rst            - 100 MHz clock, async active-high reset
//                trig_1Hz, trig_2Hz  - one-cycle timebase pulses
//                coin_in, coin_val   - coin strobe and type (3 = invalid)
//                sel_valid, sel      - product select strobe and index
//                cancel              - refund request strobe
//                credit              - current credit, 10c units
//                dispense_motor      - high while dispensing
//                dispense_id         - product being dispensed
//                change_valid/amt    - one-cycle change strobe and value
//                coin_reject         - one-cycle coin-refused strobe
//                led_blink           - status LED
//                state_o             - current FSM state
//                sold_out            - per-product empty flags (VEND_STOCK_EN)
//  Build opt   : `define VEND_STOCK_EN adds per-product stock counters
//                (reset to 9) and the sold_out port.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [7:0] PRICE0     = 8'd50,
    parameter logic [7:0] PRICE1     = 8'd80,
    parameter logic [7:0] PRICE2     = 8'd120,
    parameter logic [7:0] PRICE3     = 8'd150,
    parameter logic [7:0] MAX_CREDIT = 8'd250,
    parameter int         TIMEOUT_S  = 30,
    parameter int         DISPENSE_S = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig_1Hz,
    input  logic       trig_2Hz,
    input  logic       coin_in,
    input  logic [1:0] coin_val,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    output logic [7:0] credit,
    output logic       dispense_motor,
    output logic [1:0] dispense_id,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       coin_reject,
    output logic       led_blink,
    output logic [1:0] state_o
`ifdef VEND_STOCK_EN
    ,
    output logic [3:0] sold_out
`endif
);

    localparam int c_TMR_W = 8;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    vend_state_t            r_state;
    logic [c_CREDIT_W-1:0]  r_credit;
    logic [c_CREDIT_W-1:0]  r_change_amt;
    logic [1:0]             r_dispense_id;
    logic                   r_motor;
    logic                   r_change_valid;
    logic                   r_coin_reject;
    logic                   r_led;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    vend_state_t            w_next_state;
    logic [c_CREDIT_W-1:0]  w_next_credit;
    logic [c_CREDIT_W-1:0]  w_next_change;
    logic [1:0]             w_next_id;
    logic                   w_next_led;
    logic                   w_start_dispense;
    logic                   w_flash;

    logic [c_CREDIT_W-1:0]  w_coin_units;
    logic [c_CREDIT_W:0]    w_sum;
    logic                   w_coin_accept;
    logic [c_CREDIT_W-1:0]  w_credit_acc;
    logic [c_CREDIT_W-1:0]  w_price;
    logic                   w_in_stock;
    logic                   w_sel_ok;
    logic                   w_timeout;
    logic                   w_disp_done;

    // ------------------------------------------------------------------
    // Coin evaluation. A coin is only accepted while credit can be
    // collected and only if it does not push credit past MAX_CREDIT.
    // ------------------------------------------------------------------
    always_comb begin
        w_coin_units  = coin_units(coin_val);
        w_sum         = {1'b0, r_credit} + {1'b0, w_coin_units};
        w_coin_accept = coin_in
                        && (coin_val != c_COIN_INVALID)
                        && ((r_state == ST_IDLE) || (r_state == ST_COLLECT))
                        && (w_sum <= {1'b0, MAX_CREDIT});
        w_credit_acc  = w_coin_accept ? w_sum[c_CREDIT_W-1:0] : r_credit;
    end

    always_comb begin
        w_price = PRICE0;
        case (sel)
            2'd0:    w_price = PRICE0;
            2'd1:    w_price = PRICE1;
            2'd2:    w_price = PRICE2;
            default: w_price = PRICE3;
        endcase
    end

    // Selection is judged on the credit held before any same-cycle coin.
    assign w_sel_ok = (r_credit >= w_price) && w_in_stock;

    // ------------------------------------------------------------------
    // Timers: inactivity (restarted by every accepted coin) and dispense
    // ------------------------------------------------------------------
    sec_tick_timer #(
        .WIDTH (c_TMR_W)
    ) u_timeout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_coin_accept),
        .load_val (c_TMR_W'(TIMEOUT_S)),
        .run      (r_state == ST_COLLECT),
        .tick     (trig_1Hz),
        .done     (w_timeout)
    );

    sec_tick_timer #(
        .WIDTH (c_TMR_W)
    ) u_dispense_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_start_dispense),
        .load_val (c_TMR_W'(DISPENSE_S)),
        .run      (r_state == ST_DISPENSE),
        .tick     (trig_1Hz),
        .done     (w_disp_done)
    );

    // ------------------------------------------------------------------
    // Optional stock tracking
    // ------------------------------------------------------------------
`ifdef VEND_STOCK_EN
    logic [3:0] w_has_stock;

    for (genvar gi = 0; gi < 4; gi++) begin : g_stock
        logic [3:0] r_count;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_count <= 4'd9;
            end else if (w_start_dispense && (w_next_id == 2'(gi)) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
        end

        assign w_has_stock[gi] = (r_count != 4'd0);
    end

    assign w_in_stock = w_has_stock[sel];
    assign sold_out   = ~w_has_stock;
`else
    assign w_in_stock = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state     = r_state;
        w_next_credit    = r_credit;
        w_next_change    = r_change_amt;
        w_next_id        = r_dispense_id;
        w_start_dispense = 1'b0;
        w_flash          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Selection and cancel are meaningless without credit.
                if (w_coin_accept) begin
                    w_next_credit = w_credit_acc;
                    w_next_state  = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                w_next_credit = w_credit_acc;
                if (cancel) begin
                    w_next_change = w_credit_acc;
                    w_next_credit = '0;
                    w_next_state  = ST_RETURN;
                end else if (sel_valid) begin
                    if (w_sel_ok) begin
                        // w_credit_acc >= r_credit >= price: no underflow.
                        w_next_id        = sel;
                        w_next_change    = w_credit_acc - w_price;
                        w_next_credit    = '0;
                        w_next_state     = ST_DISPENSE;
                        w_start_dispense = 1'b1;
                    end else begin
                        w_flash = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_change = w_credit_acc;
                    w_next_credit = '0;
                    w_next_state  = ST_RETURN;
                end
            end

            ST_DISPENSE: begin
                if (w_disp_done) begin
                    w_next_state = ST_RETURN;
                end
            end

            ST_RETURN: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // LED: toggles on 2 Hz while dispensing (starting dark), and in
    // COLLECT holds a refusal flash until the next 2 Hz boundary.
    always_comb begin
        w_next_led = 1'b0;
        if (w_next_state == ST_DISPENSE) begin
            if (r_state == ST_DISPENSE) begin
                w_next_led = trig_2Hz ? ~r_led : r_led;
            end
        end else if (w_next_state == ST_COLLECT) begin
            if (w_flash) begin
                w_next_led = 1'b1;
            end else if (!trig_2Hz) begin
                w_next_led = r_led;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_change_amt   <= '0;
            r_dispense_id  <= '0;
            r_motor        <= 1'b0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_led          <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_credit       <= w_next_credit;
            r_change_amt   <= w_next_change;
            r_dispense_id  <= w_next_id;
            r_motor        <= (w_next_state == ST_DISPENSE);
            r_change_valid <= (w_next_state == ST_RETURN);
            r_coin_reject  <= coin_in && !w_coin_accept;
            r_led          <= w_next_led;
        end
    end

    assign credit         = r_credit;
    assign change_amt     = r_change_amt;
    assign dispense_id    = r_dispense_id;
    assign dispense_motor = r_motor;
    assign change_valid   = r_change_valid;
    assign coin_reject    = r_coin_reject;
    assign led_blink      = r_led;
    assign state_o        = r_state;

endmodule
`default_nettype wire
